// File: rtl/ayatsuki_bus_arb_pkg.sv
// Shared widths, slave address map, FSM and slave-select encodings for the ayatsuki bus arbiter.
// Pure definitions: no logic, no latency, no backpressure.
package ayatsuki_bus_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] TIM_START  = 32'h4000_0000;
    localparam logic [ADDR_W-1:0] TIM_END    = 32'h4000_00FF;
    localparam logic [ADDR_W-1:0] UART_START = 32'h4000_1000;
    localparam logic [ADDR_W-1:0] UART_END   = 32'h4000_10FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN0  = 2'b01,
        ST_OWN1  = 2'b10,
        ST_LOCK0 = 2'b11
    } arb_state_t;

    typedef enum logic [1:0] {
        SEL_MEM  = 2'd0,
        SEL_TIM  = 2'd1,
        SEL_UART = 2'd2
    } slave_sel_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] lo,
                                      input logic [ADDR_W-1:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/ayatsuki_bus_decode.sv
// Maps a bus address to a slave select (mem by default, tim/uart by inclusive range).
// Purely combinational, zero latency; no backpressure.
module ayatsuki_bus_decode
    import ayatsuki_bus_arb_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output slave_sel_t        o_sel
);

    always_comb begin
        o_sel = SEL_MEM;
        if (in_range(i_addr, TIM_START, TIM_END)) begin
            o_sel = SEL_TIM;
        end else if (in_range(i_addr, UART_START, UART_END)) begin
            o_sel = SEL_UART;
        end
    end

endmodule

// File: rtl/ayatsuki_bus_arb.sv
// Two-master (core m0, DMA m1) bus arbiter with m1 anti-starvation and an m0 bus lock.
// Grant is same-cycle, read data returns one cycle after grant; a master stalls by holding req until gnt.
module ayatsuki_bus_arb
    import ayatsuki_bus_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_w_enable,
    output logic              bus_r_enable,
    output logic              bus_enable,
    output logic [ADDR_W-1:0] bus_w_addr,
    output logic [ADDR_W-1:0] bus_r_addr,
    output logic [DATA_W-1:0] bus_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic [DATA_W-1:0] tim_r_data,
    input  logic [DATA_W-1:0] uart_r_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_starve_nxt;
    logic              r_rd_own0;
    logic              r_rd_own1;
    logic [ADDR_W-1:0] r_rd_addr;

    logic              w_starved;
    logic              w_m0_gnt;
    logic              w_m1_gnt;
    logic              w_gnt_any;
    logic              w_we;
    logic              w_rd_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    slave_sel_t        w_rd_sel;

    assign w_starved = (r_starve_cnt == CNT_MAX) && m1_req;

    always_comb begin
        w_m0_gnt     = 1'b0;
        w_m1_gnt     = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        if (r_state == ST_LOCK0) begin
            // m1 is shut out entirely; the starvation count is deliberately not advanced here
            w_m0_gnt = m0_req;
            if (m0_req && !m0_lock) begin
                w_state_nxt = ST_OWN0;
            end
        end else begin
            if (m0_req && !w_starved) begin
                w_m0_gnt = 1'b1;
            end else if (m1_req) begin
                w_m1_gnt = 1'b1;
            end

            if (w_m0_gnt) begin
                w_state_nxt = m0_lock ? ST_LOCK0 : ST_OWN0;
            end else if (w_m1_gnt) begin
                w_state_nxt = ST_OWN1;
            end else begin
                w_state_nxt = ST_IDLE;
            end

            if (w_m1_gnt || !m1_req) begin
                w_starve_nxt = '0;
            end else if (w_m0_gnt && (r_starve_cnt != CNT_MAX)) begin
                w_starve_nxt = r_starve_cnt + 1'b1;
            end
        end
    end

    assign w_gnt_any = w_m0_gnt | w_m1_gnt;
    assign w_we      = w_m0_gnt ? m0_we    : m1_we;
    assign w_addr    = w_m0_gnt ? m0_addr  : m1_addr;
    assign w_wdata   = w_m0_gnt ? m0_wdata : m1_wdata;
    assign w_rd_gnt  = w_gnt_any & ~w_we;

    // Combinational strobes are gated by rst_n so the bus goes quiet the instant reset asserts
    assign m0_gnt       = w_m0_gnt & rst_n;
    assign m1_gnt       = w_m1_gnt & rst_n;
    assign bus_enable   = w_gnt_any & rst_n;
    assign bus_w_enable = bus_enable & w_we;
    assign bus_r_enable = bus_enable & ~w_we;
    assign bus_w_addr   = bus_w_enable ? w_addr  : '0;
    assign bus_w_data   = bus_w_enable ? w_wdata : '0;
    assign bus_r_addr   = bus_r_enable ? w_addr  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_rd_own0    <= 1'b0;
            r_rd_own1    <= 1'b0;
            r_rd_addr    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_rd_own0    <= w_rd_gnt & w_m0_gnt;
            r_rd_own1    <= w_rd_gnt & w_m1_gnt;
            if (w_rd_gnt) begin
                r_rd_addr <= w_addr;
            end
        end
    end

    ayatsuki_bus_decode u_decode (
        .i_addr (r_rd_addr),
        .o_sel  (w_rd_sel)
    );

    assign m0_rvalid = r_rd_own0;
    assign m1_rvalid = r_rd_own1;

    always_comb begin
        rdata = '0;
        if (r_rd_own0 || r_rd_own1) begin
            case (w_rd_sel)
                SEL_TIM:  rdata = tim_r_data;
                SEL_UART: rdata = uart_r_data;
                default:  rdata = mem_r_data;
            endcase
        end
    end

endmodule

// File: tb/tb_ayatsuki_bus_arb.sv
// Directed, table-driven bench for ayatsuki_bus_arb: one vector per clock, plus hand-written reset sequences.
module tb_ayatsuki_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] rdata;
    logic        bus_w_enable, bus_r_enable, bus_enable;
    logic [31:0] bus_w_addr, bus_r_addr, bus_w_data;
    logic [31:0] mem_r_data, tim_r_data, uart_r_data;

    always #5 clk = ~clk;

    ayatsuki_bus_arb #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_lock      (m0_lock),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m0_gnt       (m0_gnt),
        .m1_gnt       (m1_gnt),
        .m0_rvalid    (m0_rvalid),
        .m1_rvalid    (m1_rvalid),
        .rdata        (rdata),
        .bus_w_enable (bus_w_enable),
        .bus_r_enable (bus_r_enable),
        .bus_enable   (bus_enable),
        .bus_w_addr   (bus_w_addr),
        .bus_r_addr   (bus_r_addr),
        .bus_w_data   (bus_w_data),
        .mem_r_data   (mem_r_data),
        .tim_r_data   (tim_r_data),
        .uart_r_data  (uart_r_data)
    );

    typedef struct packed {
        logic        m0_req;
        logic        m0_we;
        logic        m0_lock;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [31:0] mem;
        logic [31:0] tim;
        logic [31:0] uart;
    } in_t;

    typedef struct packed {
        logic        m0_gnt;
        logic        m1_gnt;
        logic        m0_rvalid;
        logic        m1_rvalid;
        logic [31:0] rdata;
        logic        bus_w_enable;
        logic        bus_r_enable;
        logic        bus_enable;
        logic [31:0] bus_w_addr;
        logic [31:0] bus_r_addr;
        logic [31:0] bus_w_data;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    vec_t vecs[$];
    in_t  vi;
    out_t vo;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic clr();
        vi = '0;
        vo = '0;
    endtask

    task automatic sd(input logic [31:0] mem, input logic [31:0] tim, input logic [31:0] uart);
        vi.mem  = mem;
        vi.tim  = tim;
        vi.uart = uart;
    endtask

    task automatic m0(input logic we, input logic lock, input logic [31:0] a, input logic [31:0] d);
        vi.m0_req   = 1'b1;
        vi.m0_we    = we;
        vi.m0_lock  = lock;
        vi.m0_addr  = a;
        vi.m0_wdata = d;
    endtask

    task automatic m1(input logic we, input logic [31:0] a, input logic [31:0] d);
        vi.m1_req   = 1'b1;
        vi.m1_we    = we;
        vi.m1_addr  = a;
        vi.m1_wdata = d;
    endtask

    task automatic gnt(input logic which, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (which) vo.m1_gnt = 1'b1;
        else       vo.m0_gnt = 1'b1;
        vo.bus_enable = 1'b1;
        if (we) begin
            vo.bus_w_enable = 1'b1;
            vo.bus_w_addr   = a;
            vo.bus_w_data   = d;
        end else begin
            vo.bus_r_enable = 1'b1;
            vo.bus_r_addr   = a;
        end
    endtask

    task automatic rv(input logic which, input logic [31:0] data);
        if (which) vo.m1_rvalid = 1'b1;
        else       vo.m0_rvalid = 1'b1;
        vo.rdata = data;
    endtask

    task automatic add(input string n);
        vec_t v;
        v.name = n;
        v.i    = vi;
        v.o    = vo;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t x);
        m0_req      = x.m0_req;
        m0_we       = x.m0_we;
        m0_lock     = x.m0_lock;
        m0_addr     = x.m0_addr;
        m0_wdata    = x.m0_wdata;
        m1_req      = x.m1_req;
        m1_we       = x.m1_we;
        m1_addr     = x.m1_addr;
        m1_wdata    = x.m1_wdata;
        mem_r_data  = x.mem;
        tim_r_data  = x.tim;
        uart_r_data = x.uart;
    endtask

    function automatic out_t sample();
        out_t s;
        s.m0_gnt       = m0_gnt;
        s.m1_gnt       = m1_gnt;
        s.m0_rvalid    = m0_rvalid;
        s.m1_rvalid    = m1_rvalid;
        s.rdata        = rdata;
        s.bus_w_enable = bus_w_enable;
        s.bus_r_enable = bus_r_enable;
        s.bus_enable   = bus_enable;
        s.bus_w_addr   = bus_w_addr;
        s.bus_r_addr   = bus_r_addr;
        s.bus_w_data   = bus_w_data;
        return s;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        // Requests are high during reset: every output must still read zero
        sd(32'h11, 32'h77, 32'hA5);
        m0(1'b0, 1'b0, 32'h100, 32'h0);
        m1(1'b0, 32'h200, 32'h0);
        drive(vi);
        #3;
        clr();
        check("in_reset_all_zero", vo);
        drive(vi);
        #9 rst_n = 1'b1;

        // Tie, back-to-back alternating reads with no bubbles
        clr(); add("idle_after_reset");
        clr(); sd(32'h11, 0, 0); m0(0, 0, 32'h100, 0); m1(0, 32'h200, 0);
        gnt(0, 0, 32'h100, 0); add("tie_m0_read_wins");
        clr(); sd(32'h11, 0, 0); m1(0, 32'h200, 0);
        gnt(1, 0, 32'h200, 0); rv(0, 32'h11); add("m1_gnt_m0_rvalid");
        clr(); sd(32'h22, 0, 0); m0(0, 0, 32'h104, 0);
        gnt(0, 0, 32'h104, 0); rv(1, 32'h22); add("m0_gnt_m1_rvalid");
        clr(); sd(32'h33, 0, 0); rv(0, 32'h33); add("m0_rvalid_tail");
        clr(); add("idle_no_rvalid");
        clr(); m1(1, 32'h300, 32'hDEAD_BEEF);
        gnt(1, 1, 32'h300, 32'hDEAD_BEEF); add("m1_write");
        clr(); add("no_rvalid_after_write");

        // Starvation: four m0 grants, then m1 forced in, then m0 again
        for (int k = 0; k < 6; k++) begin
            clr(); m0(1, 0, 32'h400 + 32'(4 * k), 32'(k)); m1(1, 32'h800, 32'hBB);
            if (k == 4) gnt(1, 1, 32'h800, 32'hBB);
            else        gnt(0, 1, 32'h400 + 32'(4 * k), 32'(k));
            add($sformatf("starve_c%0d", k));
        end
        clr(); add("idle_after_starve");

        // Lock: m1 blocked while m0 idles in LOCK0
        clr(); m0(1, 1, 32'h500, 32'h55); m1(1, 32'h600, 32'h66);
        gnt(0, 1, 32'h500, 32'h55); add("lock_m0_write");
        for (int k = 0; k < 3; k++) begin
            clr(); m1(1, 32'h600, 32'h66); add($sformatf("lock_m1_blocked_%0d", k));
        end
        clr(); m0(1, 0, 32'h504, 32'h56); m1(1, 32'h600, 32'h66);
        gnt(0, 1, 32'h504, 32'h56); add("lock_release_m0");
        clr(); m1(1, 32'h600, 32'h66);
        gnt(1, 1, 32'h600, 32'h66); add("post_lock_m1_gnt");

        // Long locked burst must not advance the starvation count
        for (int k = 0; k < 5; k++) begin
            clr(); m0(1, 1, 32'h700, 32'(k)); m1(1, 32'h600, 32'h66);
            gnt(0, 1, 32'h700, 32'(k)); add($sformatf("lock_burst_%0d", k));
        end
        clr(); m0(1, 0, 32'h704, 32'h77); m1(1, 32'h600, 32'h66);
        gnt(0, 1, 32'h704, 32'h77); add("lock_burst_release");
        clr(); m0(1, 0, 32'h708, 32'h78); m1(1, 32'h600, 32'h66);
        gnt(0, 1, 32'h708, 32'h78); add("frozen_cnt_m0_wins");
        clr(); add("idle_after_lock");

        // Address decode boundaries
        clr(); sd(32'h11, 32'h77, 32'hA5); m1(0, 32'h4000_1000, 0);
        gnt(1, 0, 32'h4000_1000, 0); add("m1_rd_uart_start");
        clr(); sd(32'h11, 32'h77, 32'hA5); m1(0, 32'h4000_00FF, 0);
        gnt(1, 0, 32'h4000_00FF, 0); rv(1, 32'hA5); add("m1_rd_tim_end");
        clr(); sd(32'h11, 32'h77, 32'hA5); m1(0, 32'h4000_0100, 0);
        gnt(1, 0, 32'h4000_0100, 0); rv(1, 32'h77); add("m1_rd_past_tim");
        clr(); sd(32'h11, 32'h77, 32'hA5); m1(0, 32'h4000_10FF, 0);
        gnt(1, 0, 32'h4000_10FF, 0); rv(1, 32'h11); add("m1_rd_uart_end");
        clr(); sd(32'h11, 32'h77, 32'hA5); m0(0, 0, 32'h4000_0FFF, 0);
        gnt(0, 0, 32'h4000_0FFF, 0); rv(1, 32'hA5); add("m0_rd_before_uart");
        clr(); sd(32'h11, 32'h77, 32'hA5); rv(0, 32'h11); add("rd_tail_mem");
        clr(); add("idle_end");

        foreach (vecs[n]) begin
            @(posedge clk);
            #1 drive(vecs[n].i);
            @(negedge clk);
            check(vecs[n].name, vecs[n].o);
        end

        // Reset the cycle after a read grant: outputs clear at once, nothing returns afterwards
        @(posedge clk);
        #1;
        clr(); sd(32'h99, 32'h77, 32'hA5); m0(0, 0, 32'h100, 0);
        drive(vi);
        gnt(0, 0, 32'h100, 0);
        @(negedge clk);
        check("pre_reset_read_gnt", vo);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vo = '0;
        check("async_reset_outputs_zero", vo);
        @(negedge clk);
        clr(); sd(32'h99, 32'h77, 32'hA5);
        drive(vi);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("no_rvalid_after_reset_%0d", k), vo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ayatsuki_bus_arb.md
AYATSUKI_BUS_ARB -- requirements
Module: ayatsuki_bus_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning max consecutive m0 grants while m1 waits.
REQ-002 SHALL have port clk  in  1  single clock (div_clk domain).
REQ-003 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports m0_req, m0_we, m0_lock  in  1 each  core request, write flag, hold-bus flag.
REQ-005 SHALL have ports m0_addr, m0_wdata  in  32 each  core address and write data.
REQ-006 SHALL have ports m1_req, m1_we  in  1 each  DMA request and write flag.
REQ-007 SHALL have ports m1_addr, m1_wdata  in  32 each  DMA address and write data.
REQ-008 SHALL have ports m0_gnt, m1_gnt  out  1 each  transfer accepted this cycle.
REQ-009 SHALL have ports m0_rvalid, m1_rvalid  out  1 each  read data valid, one cycle after grant.
REQ-010 SHALL have port rdata  out  32  shared read-return data.
REQ-011 SHALL have ports bus_w_enable, bus_r_enable, bus_enable  out  1 each  slave strobes.
REQ-012 SHALL have ports bus_w_addr, bus_r_addr, bus_w_data  out  32 each  slave address/data.
REQ-013 SHALL have ports mem_r_data, tim_r_data, uart_r_data  in  32 each  slave read data, 1-cycle latency.

Function
REQ-014 SHALL implement FSM states IDLE, OWN0, OWN1, LOCK0.
REQ-015 SHALL grant combinationally in the request cycle: m0 wins ties unless starve_cnt == STARVE_MAX and m1_req, then m1 wins.
REQ-016 SHALL in IDLE/OWN0/OWN1 go next cycle to OWN0 on m0 grant, OWN1 on m1 grant, IDLE if no request.
REQ-017 SHALL enter LOCK0 on an m0 grant with m0_lock=1; in LOCK0 grant only m0, m1_gnt=0, starve_cnt frozen.
REQ-018 SHALL leave LOCK0 on the first cycle m0_req=1 and m0_lock=0 (that transfer granted, then normal rules); m0_req=0 in LOCK0 holds LOCK0.
REQ-019 SHALL increment starve_cnt (saturate at STARVE_MAX) on each m0 grant while m1_req=1; clear it on any m1 grant or when m1_req=0.
REQ-020 SHALL drive the granted master onto the bus: write -> bus_w_enable=1, bus_w_addr/bus_w_data = master values; read -> bus_r_enable=1, bus_r_addr = master addr; bus_enable = grant active.
REQ-021 SHALL hold all bus outputs at 0 when no grant.
REQ-022 SHALL register read owner and bus_r_addr on a read grant; next cycle assert that owner's rvalid for exactly one cycle.
REQ-023 SHALL select rdata from the registered address: tim range -> tim_r_data, uart range (start..end inclusive) -> uart_r_data, else mem_r_data; rdata = 0 when no rvalid.
REQ-024 SHALL allow back-to-back reads from alternating masters with one return per cycle, no bubbles.
REQ-025 SHALL never assert m0_gnt and m1_gnt together.

Reset
REQ-026 SHALL while rst_n=0 force state IDLE, starve_cnt 0, read-owner/address registers 0, all gnt/rvalid/bus strobes 0, rdata 0.
REQ-027 SHALL on reset mid-transfer drop any pending rvalid; no data returned after release.

Structure
REQ-028 SHALL take tim/uart address ranges, data/address widths and FSM state encodings from the shared define.v.
REQ-029 SHALL contain one sub-module, ayatsuki_bus_decode, mapping a 32-bit address to a 2-bit slave select.

Verification
REQ-030 SHALL cover: m0 and m1 read together, mem_r_data=0x11 -> m0_gnt cycle 0, m0_rvalid rdata=0x11 cycle 1, m1 granted cycle 1.
REQ-031 SHALL cover: m0_req held high 6 cycles with m1_req high -> m1_gnt on cycle 4 (STARVE_MAX=4), then starve_cnt=0.
REQ-032 SHALL cover: m0 write with m0_lock=1, then 3 cycles m0_req=0 with m1_req=1 -> m1_gnt=0 until m0 issues an unlocked transfer.
REQ-033 SHALL cover: m1 read at the uart start address, uart_r_data=0xA5 -> m1_rvalid, rdata=0xA5; read at the tim end address returns tim_r_data.
REQ-034 SHALL cover: rst_n asserted the cycle after a read grant -> no rvalid, all outputs 0 immediately (asynchronous).
